// File: rtl/i2c_eeprom_slave_pkg.sv
// Shared types and constants for the i2c_eeprom_slave I2C EEPROM target.
// Optional write protect is enabled by defining I2C_EEPROM_WP_EN.
package i2c_eeprom_slave_pkg;

  localparam logic [3:0] DEV_ID_DEFAULT = 4'b1010;
  localparam int         ADDR_W         = 11;
  localparam int         RW_BIT         = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CTRL,
    ST_CTRL_ACK,
    ST_WADDR,
    ST_WADDR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RLOAD,
    ST_RDATA,
    ST_RACK,
    ST_NACK_WAIT
  } state_t;

  // Increment only the low page_bits of the address; upper bits stay put.
  function automatic logic [ADDR_W-1:0] page_inc(input logic [ADDR_W-1:0] addr,
                                                 input int page_bits);
    logic [ADDR_W-1:0] mask;
    mask = ADDR_W'((1 << page_bits) - 1);
    return (addr & ~mask) | ((addr + ADDR_W'(1)) & mask);
  endfunction

endpackage

// File: rtl/i2c_eeprom_slave_bus_sync.sv
// i2c_bus_sync: synchronizes SCL/SDA onto the system clock and flags
// SCL edges plus START/STOP conditions from the synchronized values.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic                   scl_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
  end

  // Idle bus level is high, so the chains reset to 1 to avoid phantom edges.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// I2C target emulating a 2K x 8 EEPROM behind a synchronous memory port.
// Define I2C_EEPROM_WP_EN to add the WP input that NACKs and blocks data writes.
module i2c_eeprom_slave
  import i2c_eeprom_slave_pkg::*;
#(
  parameter logic [3:0] DEV_ID      = DEV_ID_DEFAULT,
  parameter int         SYNC_STAGES = 2,
  parameter int         PAGE_BITS   = 4
) (
  input  logic              CLK,
  input  logic              RESET,
`ifdef I2C_EEPROM_WP_EN
  input  logic              WP,
`endif
  input  logic              SCL,
  input  logic              SDA_IN,
  output logic              SDA_OE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [7:0]        MEM_WDATA,
  output logic              MEM_WE,
  output logic              MEM_RE,
  input  logic [7:0]        MEM_RDATA,
  output logic              BUSY
);

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_sync (
    .clk      (CLK),
    .reset_n  (RESET),
    .scl      (SCL),
    .sda      (SDA_IN),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_s    (sda_s),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  logic wp_active;
`ifdef I2C_EEPROM_WP_EN
  assign wp_active = WP;
`else
  assign wp_active = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [1:0]        rload_cnt_q, rload_cnt_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;

  logic receiving, byte_done;

  assign receiving = (state_q == ST_CTRL) || (state_q == ST_WADDR) || (state_q == ST_WDATA);
  assign byte_done = (bit_cnt_q == 4'd8);

  // Read bytes are fetched while SCL is high so bit 7 can go out on the next fall.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    rload_cnt_d = rload_cnt_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (start_det) begin
      state_d     = ST_CTRL;
      bit_cnt_d   = 4'd0;
      busy_d      = 1'b1;
      sda_oe_d    = 1'b0;
      rload_cnt_d = 2'd0;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else begin
      if (receiving && scl_rise && !byte_done) begin
        shift_d   = {shift_q[6:0], sda_s};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end

      case (state_q)
        ST_CTRL: begin
          if (scl_fall && byte_done) begin
            bit_cnt_d = 4'd0;
            if (shift_q[7:4] == DEV_ID) begin
              addr_d[ADDR_W-1:8] = shift_q[3:1];
              rw_d               = shift_q[RW_BIT];
              sda_oe_d           = 1'b1;
              state_d            = ST_CTRL_ACK;
            end else begin
              state_d = ST_NACK_WAIT;
            end
          end
        end

        ST_CTRL_ACK: begin
          if (rw_q && scl_rise) begin
            rload_cnt_d = 2'd0;
            state_d     = ST_RLOAD;
          end else if (!rw_q && scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = ST_WADDR;
          end
        end

        ST_WADDR: begin
          if (scl_fall && byte_done) begin
            addr_d[7:0] = shift_q;
            sda_oe_d    = 1'b1;
            state_d     = ST_WADDR_ACK;
          end
        end

        ST_WADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = ST_WDATA;
          end
        end

        ST_WDATA: begin
          if (scl_fall && byte_done) begin
            sda_oe_d = !wp_active;
            state_d  = ST_WDATA_ACK;
          end
        end

        // The write commits only once the ACK clock completes.
        ST_WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d    = 1'b0;
            bit_cnt_d   = 4'd0;
            mem_we_d    = !wp_active;
            mem_addr_d  = addr_q;
            mem_wdata_d = shift_q;
            addr_d      = page_inc(addr_q, PAGE_BITS);
            state_d     = ST_WDATA;
          end
        end

        ST_RLOAD: begin
          case (rload_cnt_q)
            2'd0: begin
              mem_re_d    = 1'b1;
              mem_addr_d  = addr_q;
              addr_d      = addr_q + ADDR_W'(1);
              rload_cnt_d = 2'd1;
            end
            2'd1: rload_cnt_d = 2'd2;
            default: begin
              shift_d     = MEM_RDATA;
              bit_cnt_d   = 4'd0;
              rload_cnt_d = 2'd0;
              state_d     = ST_RDATA;
            end
          endcase
        end

        ST_RDATA: begin
          if (scl_fall) begin
            if (!byte_done) begin
              sda_oe_d  = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_RACK;
            end
          end
        end

        ST_RACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              rload_cnt_d = 2'd0;
              state_d     = ST_RLOAD;
            end else begin
              state_d = ST_NACK_WAIT;
            end
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'd0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      rload_cnt_q <= 2'd0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      rload_cnt_q <= rload_cnt_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign SDA_OE    = sda_oe_q;
  assign BUSY      = busy_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_RE    = mem_re_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;

endmodule
